// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse command/response bytes and the init sequencer state type.
package ps2_pkg;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_EN      = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  localparam logic [7:0] RSP_ID      = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEND_RST,
    ST_WAIT_ACK_RST,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_SEND_EN,
    ST_WAIT_ACK_EN,
    ST_RETRY,
    ST_STREAM,
    ST_FAIL
  } init_state_t;

  function automatic logic is_send(input init_state_t s);
    return (s == ST_SEND_RST) || (s == ST_SEND_EN);
  endfunction

  function automatic logic is_wait(input init_state_t s);
    return (s == ST_WAIT_ACK_RST) || (s == ST_WAIT_BAT) ||
           (s == ST_WAIT_ID) || (s == ST_WAIT_ACK_EN);
  endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Response timeout: up-counter cleared on state entry, expires at TIMEOUT_CYC-1.
module ps2_timeout #(
  parameter int unsigned TW          = 25,
  parameter int unsigned TIMEOUT_CYC = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign expire_o = en_i && (cnt_q == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: reset, BAT/ID check, enable reporting, then
// gate the packet decoder; retries on error/timeout and re-inits on hot-plug.
module ps2_mouse_init_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 20_000_000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TW          = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       tx_req,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       stream_en,
  output logic       busy,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  init_state_t state_q, state_d;
  logic [1:0]  retry_q, retry_d, retry_inc;
  logic        fail_q, fail_d;
  logic        seen_aa_q, seen_aa_d;
  logic        tx_req_q, stream_en_q, busy_q;
  logic [7:0]  tx_byte_q;
  logic        at_limit, tmo, tmr_clr, tmr_en;
  logic [7:0]  rsp_exp;
  init_state_t rsp_next, resend_s;

  assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
  assign at_limit  = (retry_q == 2'(MAX_RETRY - 1));
  assign tmr_en    = is_send(state_q) || is_wait(state_q);
  // start re-enters SEND_RST even from SEND_RST, so it must also restart the timer
  assign tmr_clr   = start || (state_d != state_q);

  ps2_timeout #(.TW(TW), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (tmr_clr),
    .en_i     (tmr_en),
    .expire_o (tmo)
  );

  always_comb begin
    rsp_exp  = RSP_ACK;
    rsp_next = ST_WAIT_BAT;
    resend_s = ST_SEND_RST;
    case (state_q)
      ST_WAIT_BAT:    begin rsp_exp = RSP_BAT_OK; rsp_next = ST_WAIT_ID;  end
      ST_WAIT_ID:     begin rsp_exp = RSP_ID;     rsp_next = ST_SEND_EN;  end
      ST_WAIT_ACK_EN: begin rsp_exp = RSP_ACK;    rsp_next = ST_STREAM;
                            resend_s = ST_SEND_EN; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    fail_d    = fail_q;
    seen_aa_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_SEND_RST;
      ST_SEND_RST, ST_SEND_EN: begin
        if (tx_req_q && tx_err)       state_d = ST_RETRY;
        else if (tx_req_q && tx_done)
          state_d = (state_q == ST_SEND_EN) ? ST_WAIT_ACK_EN : ST_WAIT_ACK_RST;
        else if (tmo)                 state_d = ST_RETRY;
      end
      ST_WAIT_ACK_RST, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK_EN: begin
        if (rx_valid) begin
          if (rx_byte == rsp_exp) begin
            state_d = rsp_next;
          end else if (rx_byte == RSP_RESEND) begin
            retry_d = retry_inc;
            if (at_limit) begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d = resend_s;
            end
          end else begin
            state_d = ST_RETRY;
          end
        end else if (tmo) begin
          state_d = ST_RETRY;
        end
      end
      ST_RETRY: begin
        retry_d = retry_inc;
        if (at_limit) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
        end else begin
          state_d = ST_SEND_RST;
        end
      end
      ST_STREAM: begin
        seen_aa_d = seen_aa_q;
        if (rx_valid) begin
          if (rx_byte == RSP_BAT_OK) begin
            seen_aa_d = 1'b1;
          end else if (seen_aa_q && (rx_byte == RSP_ID)) begin
            state_d   = ST_SEND_RST;
            retry_d   = '0;
            seen_aa_d = 1'b0;
          end else begin
            seen_aa_d = 1'b0;
          end
        end
      end
      ST_FAIL: ;
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d   = ST_SEND_RST;
      retry_d   = '0;
      fail_d    = 1'b0;
      seen_aa_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      retry_q     <= '0;
      fail_q      <= 1'b0;
      seen_aa_q   <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_byte_q   <= '0;
      stream_en_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      fail_q      <= fail_d;
      seen_aa_q   <= seen_aa_d;
      // start forces a one-cycle request gap; the SEND state re-raises it next cycle
      tx_req_q    <= is_send(state_d) && !start;
      if (is_send(state_d))
        tx_byte_q <= (state_d == ST_SEND_EN) ? CMD_EN : CMD_RESET;
      stream_en_q <= (state_d == ST_STREAM);
      busy_q      <= is_send(state_d) || is_wait(state_d) || (state_d == ST_RETRY);
    end
  end

  assign tx_req    = tx_req_q;
  assign tx_byte   = tx_byte_q;
  assign stream_en = stream_en_q;
  assign busy      = busy_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: doc/ps2_mouse_init_ctrl.md
Name: ps2_mouse_init_ctrl

Overview:
- Sequences PS/2 mouse bring-up for one mouse port: reset (0xFF), BAT/ID check, then enable data reporting (0xF4).
- Sits between the byte-level PS/2 transmitter/receiver and the movement-packet decoder that produces a paddle position.
- Gates the decoder with stream_en.
- Retries on timeout or bad response; recovers from hot-plug.
- One instance per mouse port.

Parameters:
- TIMEOUT_CYC, 20_000_000: per-state response timeout in clk cycles (0.5 s at 40 MHz).
- MAX_RETRY, 3: failed attempts allowed before FAIL.
- TW, 25: timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; restart the init sequence.
- tx_req  out  1  request to transmitter to send tx_byte; held until tx_done/tx_err.
- tx_byte  out  8  command byte; stable while tx_req=1.
- tx_done  in  1  pulse; byte sent and line-level ack received.
- tx_err  in  1  pulse; line-level transmit failure.
- rx_valid  in  1  pulse; rx_byte valid this cycle.
- rx_byte  in  8  received byte.
- stream_en  out  1  mouse is streaming; enables the packet decoder.
- busy  out  1  init sequence in progress.
- fail  out  1  sticky init failure; cleared by start or reset.
- retry_cnt  out  2  attempts consumed in the current sequence.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - tx_req=0, tx_byte=0x00, stream_en=0, busy=0, fail=0, retry_cnt=0, timer=0.
- First clk edge after reset release: IDLE→SEND_RST (auto-start).
- Outputs are registered and decoded from state:
  - busy=1 in SEND_RST through WAIT_ACK_EN.
  - stream_en=1 only in STREAM.
- States:
  - SEND_RST: tx_req=1, tx_byte=0xFF. On tx_done → WAIT_ACK_RST.
  - WAIT_ACK_RST: rx 0xFA → WAIT_BAT.
  - WAIT_BAT: rx 0xAA → WAIT_ID; rx 0xFC → RETRY.
  - WAIT_ID: rx 0x00 → SEND_EN.
  - SEND_EN: tx_req=1, tx_byte=0xF4. On tx_done → WAIT_ACK_EN.
  - WAIT_ACK_EN: rx 0xFA → STREAM.
  - STREAM: terminal good state.
  - FAIL: fail=1; remain until start.
- In any WAIT_* state:
  - rx 0xFE (resend) → re-enter the preceding SEND_* state and count one retry.
  - Any other unexpected byte → RETRY.
- tx handshake:
  - tx_req rises on the cycle of entry into SEND_*.
  - It falls on the cycle after tx_done or tx_err is sampled.
  - tx_byte holds its value for the whole request.
  - tx_err → RETRY.
  - tx_done and tx_err in the same cycle: tx_err wins.
- rx_valid while in a SEND_* state or in IDLE: ignored.
- Timer:
  - Reloaded to 0 on every state entry and counts every cycle in SEND_* and WAIT_*.
  - Reaching TIMEOUT_CYC-1 → RETRY.
  - Does not run in STREAM, FAIL or IDLE.
- RETRY (single-cycle transient):
  - If retry_cnt==MAX_RETRY-1 → FAIL, with retry_cnt incremented.
  - Otherwise retry_cnt+1 and → SEND_RST.
  - retry_cnt saturates at 3 (2-bit field).
- Retries triggered by 0xFE:
  - Use the same counter and the same FAIL limit.
  - Go back to the same SEND_* state, not to SEND_RST.
- start pulse, from any state including mid-transfer:
  - Next state is SEND_RST; retry_cnt=0, fail=0.
  - tx_req drops for exactly one cycle before re-asserting.
  - start takes priority over every other event in the same cycle.
- STREAM hot-plug detect:
  - rx 0xAA sets the seen_aa flag.
  - The next rx byte 0x00 → SEND_RST with retry_cnt=0.
  - Any other byte clears seen_aa.
  - stream_en drops in the same cycle as the 0x00 is sampled (registered, visible next cycle).
- FAIL: stream_en=0, busy=0.

Decomposition:
- Package ps2_pkg contains:
  - Command constants: CMD_RESET=0xFF, CMD_EN=0xF4.
  - Response constants: RSP_ACK=0xFA, RSP_RESEND=0xFE, RSP_BAT_OK=0xAA, RSP_BAT_ERR=0xFC, RSP_ID=0x00.
  - typedef enum init_state_t.
- Sub-module ps2_timeout: loadable up-counter with clear, enable and expire output, parameterized by TW and TIMEOUT_CYC.

Test Plan:
- Nominal bring-up:
  - Stimulus: release reset; tx_done 5 cycles after tx_req; rx FA, AA, 00; then tx_done for F4; rx FA.
  - Required: tx_byte=0xFF then 0xF4; stream_en=1 one cycle after the final FA; busy=0; retry_cnt=0.
- Resend:
  - Stimulus: in WAIT_ACK_EN, rx 0xFE.
  - Required: tx_req re-asserts with tx_byte=0xF4; retry_cnt=1; a following rx FA → stream_en=1.
- Timeout to FAIL:
  - Stimulus: TIMEOUT_CYC=100; never send rx.
  - Required: three SEND_RST attempts; fail=1 after ≈3×(100+n) cycles; retry_cnt=3; tx_req=0.
- BAT error and tx_err:
  - Stimulus: rx FA then FC.
  - Required: retry_cnt=1, back to SEND_RST.
  - Stimulus: tx_done and tx_err pulsed in the same cycle.
  - Required: treated as tx_err; retry_cnt=2.
- Hot-plug in STREAM:
  - Stimulus: rx 0xAA, 0x00.
  - Required: stream_en=0, tx_byte=0xFF, retry_cnt=0.
  - Stimulus: rx 0xAA, 0x08.
  - Required: stays in STREAM.
- Async reset and start mid-transfer:
  - Stimulus: reset low with tx_req=1.
  - Required: tx_req=0 immediately, without waiting for a clock edge.
  - Stimulus: start pulse in WAIT_ID.
  - Required: tx_req low for 1 cycle, then tx_byte=0xFF; fail cleared.
